dcache_dm: RTL and testbench

Direct-mapped, write-back, write-allocate data cache that responds to the CPU-side dcache request interface (raddr/waddr/wdata/rreq/wreq/sel → rdata). It sits between the CPU load/store path and a 128-bit line-wide memory port. It serves hits with one-cycle read latency and raises `stall` while a miss is refilled or a dirty line is written back. 4 KiB capacity: 256 sets × 16-byte lines.

---
 rtl/dcache_pkg.sv | 36 +++
 rtl/dcache_line_ram.sv | 41 ++++
 rtl/dcache_dm.sv | 185 ++++++++++++++++++
 tb/tb_dcache_dm.sv | 251 +++++++++++++++++++++++++
 4 files changed

// File: rtl/dcache_pkg.sv
// Shared parameters, FSM state type and address-field helpers for the
// direct-mapped data cache.
package dcache_pkg;

    localparam int INDEX_W  = 8;
    localparam int OFFSET_W = 4;
    localparam int TAG_W    = 20;
    localparam int LINE_W   = 128;
    localparam int SETS     = 1 << INDEX_W;
    localparam int LINE_B   = LINE_W / 8;

    typedef enum logic [1:0] {
        IDLE,
        WB,
        REFILL,
        RESUME
    } state_t;

    function automatic logic [TAG_W-1:0] addr_tag(input logic [31:0] addr);
        return addr[31 -: TAG_W];
    endfunction

    function automatic logic [INDEX_W-1:0] addr_index(input logic [31:0] addr);
        return addr[OFFSET_W +: INDEX_W];
    endfunction

    function automatic logic [1:0] addr_word(input logic [31:0] addr);
        return addr[OFFSET_W-1:2];
    endfunction

    function automatic logic [31:0] line_addr(input logic [TAG_W-1:0] tag,
                                              input logic [INDEX_W-1:0] index);
        return {tag, index, {OFFSET_W{1'b0}}};
    endfunction

endpackage

// File: rtl/dcache_line_ram.sv
// Tag and data storage for the cache: asynchronous line read, tag-only probe
// read for the store address, and one byte-masked write port.
module dcache_line_ram
    import dcache_pkg::*;
(
    input  logic               clk,
    input  logic [INDEX_W-1:0] rd_index,
    output logic [TAG_W-1:0]   rd_tag,
    output logic [LINE_W-1:0]  rd_line,
    input  logic [INDEX_W-1:0] probe_index,
    output logic [TAG_W-1:0]   probe_tag,
    input  logic               wr_en,
    input  logic               wr_tag_en,
    input  logic [INDEX_W-1:0] wr_index,
    input  logic [TAG_W-1:0]   wr_tag,
    input  logic [LINE_B-1:0]  wr_mask,
    input  logic [LINE_W-1:0]  wr_data
);

    logic [TAG_W-1:0]  tag_mem  [SETS];
    logic [LINE_W-1:0] data_mem [SETS];

    assign rd_tag    = tag_mem[rd_index];
    assign rd_line   = data_mem[rd_index];
    assign probe_tag = tag_mem[probe_index];

    // A refill writes tag plus the whole line; a store writes only masked bytes.
    always_ff @(posedge clk) begin
        if (wr_en) begin
            if (wr_tag_en) begin
                tag_mem[wr_index] <= wr_tag;
            end
            for (int b = 0; b < LINE_B; b++) begin
                if (wr_mask[b]) begin
                    data_mem[wr_index][8*b +: 8] <= wr_data[8*b +: 8];
                end
            end
        end
    end

endmodule

// File: rtl/dcache_dm.sv
// Direct-mapped write-back, write-allocate data cache with a 128-bit line
// memory port; valid/dirty flops, hit logic, store forwarding and miss FSM.
module dcache_dm
    import dcache_pkg::*;
(
    input  logic              clk,
    input  logic              rst,
    input  logic              dcache_rreq_i,
    input  logic [31:0]       dcache_raddr_i,
    input  logic              dcache_wreq_i,
    input  logic [31:0]       dcache_waddr_i,
    input  logic [31:0]       dcache_wdata_i,
    input  logic [3:0]        dcache_sel_i,
    output logic [31:0]       dcache_data_o,
    output logic              stall_o,
    output logic              mem_req_o,
    output logic              mem_we_o,
    output logic [31:0]       mem_addr_o,
    output logic [LINE_W-1:0] mem_wdata_o,
    input  logic [LINE_W-1:0] mem_rdata_i,
    input  logic              mem_ack_i
);

    state_t state, state_next;
    logic [SETS-1:0] valid, dirty;

    logic [INDEX_W-1:0] r_index, w_index, a_index, miss_index, pend_index;
    logic [TAG_W-1:0]   r_tag, w_tag, a_tag, probe_tag, miss_tag, pend_tag;
    logic [1:0]         r_word, w_word;
    logic [LINE_W-1:0]  a_line;
    logic               w_hit, r_hit, w_miss, r_miss, lookup_miss, victim_dirty;
    logic [31:0]        read_word;

    logic               ram_we, ram_tag_we;
    logic [INDEX_W-1:0] ram_windex;
    logic [LINE_B-1:0]  ram_mask;
    logic [LINE_W-1:0]  ram_wdata;

    assign r_index = addr_index(dcache_raddr_i);
    assign r_tag   = addr_tag(dcache_raddr_i);
    assign r_word  = addr_word(dcache_raddr_i);
    assign w_index = addr_index(dcache_waddr_i);
    assign w_tag   = addr_tag(dcache_waddr_i);
    assign w_word  = addr_word(dcache_waddr_i);

    // The line port follows the store index on a store miss so the victim is
    // visible; the load result is irrelevant then because the store goes first.
    assign w_hit        = valid[w_index] && (probe_tag == w_tag);
    assign w_miss       = dcache_wreq_i && !w_hit;
    assign a_index      = w_miss ? w_index : r_index;
    assign r_hit        = valid[r_index] && (a_tag == r_tag);
    assign r_miss       = dcache_rreq_i && !r_hit;
    assign lookup_miss  = w_miss || r_miss;
    assign miss_index   = a_index;
    assign miss_tag     = w_miss ? w_tag : r_tag;
    assign victim_dirty = valid[miss_index] && dirty[miss_index];

    dcache_line_ram u_line_ram (
        .clk         (clk),
        .rd_index    (a_index),
        .rd_tag      (a_tag),
        .rd_line     (a_line),
        .probe_index (w_index),
        .probe_tag   (probe_tag),
        .wr_en       (ram_we),
        .wr_tag_en   (ram_tag_we),
        .wr_index    (ram_windex),
        .wr_tag      (pend_tag),
        .wr_mask     (ram_mask),
        .wr_data     (ram_wdata)
    );

    always_comb begin
        read_word = a_line[{r_word, 5'b0} +: 32];
        if (dcache_wreq_i && (dcache_waddr_i[31:2] == dcache_raddr_i[31:2])) begin
            for (int b = 0; b < 4; b++) begin
                if (dcache_sel_i[b]) begin
                    read_word[8*b +: 8] = dcache_wdata_i[8*b +: 8];
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (lookup_miss) state_next = victim_dirty ? WB : REFILL;
            WB:      if (mem_ack_i) state_next = REFILL;
            REFILL:  if (mem_ack_i) state_next = RESUME;
            RESUME:  state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_comb begin
        stall_o    = 1'b1;
        ram_we     = 1'b0;
        ram_tag_we = 1'b0;
        ram_windex = w_index;
        ram_mask   = '0;
        ram_wdata  = {4{dcache_wdata_i}};
        case (state)
            IDLE: begin
                stall_o = lookup_miss;
                if (!lookup_miss && dcache_wreq_i) begin
                    ram_we   = 1'b1;
                    ram_mask = LINE_B'(dcache_sel_i) << {w_word, 2'b00};
                end
            end
            REFILL: begin
                if (mem_ack_i) begin
                    ram_we     = 1'b1;
                    ram_tag_we = 1'b1;
                    ram_windex = pend_index;
                    ram_mask   = '1;
                    ram_wdata  = mem_rdata_i;
                end
            end
            default: ;
        endcase
    end

    // Miss bookkeeping, registered memory port, load data and valid/dirty flops.
    always_ff @(posedge clk) begin
        if (rst) begin
            valid         <= '0;
            dirty         <= '0;
            dcache_data_o <= '0;
            mem_req_o     <= 1'b0;
            mem_we_o      <= 1'b0;
            mem_addr_o    <= '0;
            mem_wdata_o   <= '0;
            pend_tag      <= '0;
            pend_index    <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (lookup_miss) begin
                        pend_tag   <= miss_tag;
                        pend_index <= miss_index;
                        mem_req_o  <= 1'b1;
                        if (victim_dirty) begin
                            mem_we_o    <= 1'b1;
                            mem_addr_o  <= line_addr(a_tag, miss_index);
                            mem_wdata_o <= a_line;
                        end else begin
                            mem_we_o   <= 1'b0;
                            mem_addr_o <= line_addr(miss_tag, miss_index);
                        end
                    end else begin
                        if (dcache_rreq_i) begin
                            dcache_data_o <= read_word;
                        end
                        if (dcache_wreq_i && (|dcache_sel_i)) begin
                            dirty[w_index] <= 1'b1;
                        end
                    end
                end
                WB: begin
                    if (mem_ack_i) begin
                        mem_we_o   <= 1'b0;
                        mem_addr_o <= line_addr(pend_tag, pend_index);
                    end
                end
                REFILL: begin
                    if (mem_ack_i) begin
                        mem_req_o         <= 1'b0;
                        valid[pend_index] <= 1'b1;
                        dirty[pend_index] <= 1'b0;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_dcache_dm.sv
// Directed self-checking bench for dcache_dm with a fixed-latency line memory.
module tb_dcache_dm;

    localparam int MEM_LAT = 2;

    logic         clk = 1'b0;
    logic         rst;
    logic         dcache_rreq_i;
    logic [31:0]  dcache_raddr_i;
    logic         dcache_wreq_i;
    logic [31:0]  dcache_waddr_i;
    logic [31:0]  dcache_wdata_i;
    logic [3:0]   dcache_sel_i;
    logic [31:0]  dcache_data_o;
    logic         stall_o;
    logic         mem_req_o;
    logic         mem_we_o;
    logic [31:0]  mem_addr_o;
    logic [127:0] mem_wdata_o;
    logic [127:0] mem_rdata_i = '0;
    logic         mem_ack_i = 1'b0;

    logic [127:0] mem_model [logic [31:0]];
    int           lat_cnt = 0;
    int           refill_count = 0;
    int           wb_count = 0;
    logic [31:0]  last_refill_addr = '0;
    logic [31:0]  last_wb_addr = '0;
    logic [127:0] last_wb_data = '0;
    int           check_count = 0;
    int           pass_count = 0;
    int           fail_count = 0;

    always #5 clk = ~clk;

    dcache_dm dut (
        .clk            (clk),
        .rst            (rst),
        .dcache_rreq_i  (dcache_rreq_i),
        .dcache_raddr_i (dcache_raddr_i),
        .dcache_wreq_i  (dcache_wreq_i),
        .dcache_waddr_i (dcache_waddr_i),
        .dcache_wdata_i (dcache_wdata_i),
        .dcache_sel_i   (dcache_sel_i),
        .dcache_data_o  (dcache_data_o),
        .stall_o        (stall_o),
        .mem_req_o      (mem_req_o),
        .mem_we_o       (mem_we_o),
        .mem_addr_o     (mem_addr_o),
        .mem_wdata_o    (mem_wdata_o),
        .mem_rdata_i    (mem_rdata_i),
        .mem_ack_i      (mem_ack_i)
    );

    function automatic logic [127:0] default_line(input logic [31:0] a);
        return {a + 32'hC, a + 32'h8, a + 32'h4, a};
    endfunction

    // Memory answers each request with a one-cycle ack after MEM_LAT idle cycles.
    always @(negedge clk) begin
        mem_ack_i = 1'b0;
        if (!mem_req_o) begin
            lat_cnt = 0;
        end else if (lat_cnt == MEM_LAT) begin
            mem_ack_i = 1'b1;
            lat_cnt = 0;
            if (mem_we_o) begin
                wb_count++;
                last_wb_addr = mem_addr_o;
                last_wb_data = mem_wdata_o;
                mem_model[mem_addr_o] = mem_wdata_o;
            end else begin
                refill_count++;
                last_refill_addr = mem_addr_o;
                mem_rdata_i = mem_model.exists(mem_addr_o) ? mem_model[mem_addr_o]
                                                           : default_line(mem_addr_o);
            end
        end else begin
            lat_cnt++;
        end
    end

    task automatic checkOutput(input string tag, input logic [127:0] observed,
                               input logic [127:0] expected);
        check_count++;
        assert (observed === expected) pass_count++;
        else begin
            fail_count++;
            $error("[TB] FAIL %s: observed %0h expected %0h", tag, observed, expected);
        end
    endtask

    task automatic applyReset();
        rst = 1'b1;
        dcache_rreq_i = 1'b0;
        dcache_wreq_i = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
    endtask

    // Holds the request until accepted and returns the number of stalled cycles.
    task automatic applyStimulus(input logic rr, input logic [31:0] ra,
                                 input logic wr, input logic [31:0] wa,
                                 input logic [31:0] wd, input logic [3:0] s,
                                 output int stalls);
        dcache_rreq_i  = rr;
        dcache_raddr_i = ra;
        dcache_wreq_i  = wr;
        dcache_waddr_i = wa;
        dcache_wdata_i = wd;
        dcache_sel_i   = s;
        stalls = 0;
        @(negedge clk);
        while (stall_o && stalls < 40) begin
            stalls++;
            @(negedge clk);
        end
        checkOutput("stall_timeout", 128'(stall_o), 128'h0);
        @(posedge clk);
        #1;
        dcache_rreq_i = 1'b0;
        dcache_wreq_i = 1'b0;
    endtask

    initial begin
        int          stalls;
        int          stall_total;
        int          k;
        int          refills_before;
        int          wbs_before;
        logic [31:0] wvals [16];

        dcache_raddr_i = '0;
        dcache_waddr_i = '0;
        dcache_wdata_i = '0;
        dcache_sel_i   = '0;
        mem_model[32'h10] = 128'h00000004_00000003_00000002_00000001;

        rst = 1'b1;
        dcache_rreq_i = 1'b0;
        dcache_wreq_i = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        checkOutput("reset_data",   128'(dcache_data_o), 128'h0);
        checkOutput("reset_stall",  128'(stall_o),       128'h0);
        checkOutput("reset_req",    128'(mem_req_o),     128'h0);
        checkOutput("reset_we",     128'(mem_we_o),      128'h0);
        checkOutput("reset_addr",   128'(mem_addr_o),    128'h0);
        checkOutput("reset_wdata",  mem_wdata_o,         128'h0);
        rst = 1'b0;

        $display("[TB] cold read miss");
        applyStimulus(1'b1, 32'h10, 1'b0, 32'h0, 32'h0, 4'h0, stalls);
        checkOutput("cold_stalls",      128'(stalls),           128'd5);
        checkOutput("cold_refill_addr", 128'(last_refill_addr), 128'h10);
        checkOutput("cold_data",        128'(dcache_data_o),    128'h1);
        checkOutput("cold_req_dropped", 128'(mem_req_o),        128'h0);
        applyStimulus(1'b1, 32'h10, 1'b0, 32'h0, 32'h0, 4'h0, stalls);
        checkOutput("rehit_stalls", 128'(stalls),        128'd0);
        checkOutput("rehit_data",   128'(dcache_data_o), 128'h1);
        applyStimulus(1'b1, 32'h14, 1'b0, 32'h0, 32'h0, 4'h0, stalls);
        checkOutput("word1_data",   128'(dcache_data_o), 128'h2);

        $display("[TB] write-allocate stream");
        applyReset();
        refills_before = refill_count;
        wbs_before = wb_count;
        for (int i = 0; i < 16; i++) begin
            wvals[i] = $urandom;
            applyStimulus(1'b0, 32'h0, 1'b1, 32'(i * 16), wvals[i], 4'hF, stalls);
        end
        stall_total = 0;
        for (int i = 0; i < 16; i++) begin
            k = $urandom_range(0, 15);
            applyStimulus(1'b1, 32'(k * 16), 1'b0, 32'h0, 32'h0, 4'h0, stalls);
            stall_total += stalls;
            checkOutput("stream_read", 128'(dcache_data_o), 128'(wvals[k]));
        end
        checkOutput("stream_read_stalls", 128'(stall_total),                128'd0);
        checkOutput("stream_refills",     128'(refill_count - refills_before), 128'd16);
        checkOutput("stream_writebacks",  128'(wb_count - wbs_before),         128'd0);

        $display("[TB] byte enables");
        applyStimulus(1'b0, 32'h0, 1'b1, 32'h30, 32'h11223344, 4'hF, stalls);
        applyStimulus(1'b0, 32'h0, 1'b1, 32'h30, 32'hAABBCCDD, 4'b0101, stalls);
        applyStimulus(1'b1, 32'h30, 1'b0, 32'h0, 32'h0, 4'h0, stalls);
        checkOutput("sel_0101", 128'(dcache_data_o), 128'h11BB33DD);
        applyStimulus(1'b0, 32'h0, 1'b1, 32'h34, 32'h11223344, 4'hF, stalls);
        applyStimulus(1'b0, 32'h0, 1'b1, 32'h34, 32'hAABBCCDD, 4'b0100, stalls);
        applyStimulus(1'b1, 32'h34, 1'b0, 32'h0, 32'h0, 4'h0, stalls);
        checkOutput("sel_0100", 128'(dcache_data_o), 128'h11BB3344);
        applyStimulus(1'b0, 32'h0, 1'b1, 32'h38, 32'h11223344, 4'hF, stalls);
        applyStimulus(1'b0, 32'h0, 1'b1, 32'h38, 32'hFFFFFFFF, 4'b0000, stalls);
        applyStimulus(1'b1, 32'h38, 1'b0, 32'h0, 32'h0, 4'h0, stalls);
        checkOutput("sel_0000_data", 128'(dcache_data_o), 128'h11223344);

        $display("[TB] empty-mask store leaves line clean");
        wbs_before = wb_count;
        applyStimulus(1'b1, 32'h100, 1'b0, 32'h0, 32'h0, 4'h0, stalls);
        applyStimulus(1'b0, 32'h0, 1'b1, 32'h100, 32'hFFFFFFFF, 4'b0000, stalls);
        checkOutput("sel0_store_stalls", 128'(stalls), 128'd0);
        applyStimulus(1'b1, 32'h1100, 1'b0, 32'h0, 32'h0, 4'h0, stalls);
        checkOutput("sel0_evict_stalls", 128'(stalls),            128'd5);
        checkOutput("sel0_no_writeback", 128'(wb_count - wbs_before), 128'd0);
        checkOutput("sel0_evict_data",   128'(dcache_data_o),     128'h1100);

        $display("[TB] dirty eviction");
        wbs_before = wb_count;
        applyStimulus(1'b1, 32'h1020, 1'b0, 32'h0, 32'h0, 4'h0, stalls);
        checkOutput("dirty_stalls",      128'(stalls),            128'd8);
        checkOutput("dirty_wb_count",    128'(wb_count - wbs_before), 128'd1);
        checkOutput("dirty_wb_addr",     128'(last_wb_addr),      128'h20);
        checkOutput("dirty_wb_data",     last_wb_data,
                    {32'h2C, 32'h28, 32'h24, wvals[2]});
        checkOutput("dirty_refill_addr", 128'(last_refill_addr),  128'h1020);
        checkOutput("dirty_data",        128'(dcache_data_o),     128'h1020);

        $display("[TB] same-cycle store forwarding");
        applyStimulus(1'b1, 32'h30, 1'b1, 32'h30, 32'h55, 4'hF, stalls);
        checkOutput("fwd_full_stalls", 128'(stalls),        128'd0);
        checkOutput("fwd_full_data",   128'(dcache_data_o), 128'h55);
        applyStimulus(1'b1, 32'h30, 1'b1, 32'h30, 32'h0000BB00, 4'b0010, stalls);
        checkOutput("fwd_partial_data", 128'(dcache_data_o), 128'h0000BB55);
        applyStimulus(1'b1, 32'h30, 1'b0, 32'h0, 32'h0, 4'h0, stalls);
        checkOutput("fwd_committed",    128'(dcache_data_o), 128'h0000BB55);

        $display("[TB] reset during refill");
        dcache_rreq_i  = 1'b1;
        dcache_raddr_i = 32'h200;
        @(posedge clk);
        #1;
        checkOutput("abort_req_up",  128'(mem_req_o),  128'h1);
        checkOutput("abort_we",      128'(mem_we_o),   128'h0);
        checkOutput("abort_addr",    128'(mem_addr_o), 128'h200);
        rst = 1'b1;
        dcache_rreq_i = 1'b0;
        @(posedge clk);
        #1;
        checkOutput("abort_req_down", 128'(mem_req_o), 128'h0);
        checkOutput("abort_stall",    128'(stall_o),   128'h0);
        rst = 1'b0;
        applyStimulus(1'b1, 32'h30, 1'b0, 32'h0, 32'h0, 4'h0, stalls);
        checkOutput("post_reset_miss_stalls", 128'(stalls),        128'd5);
        checkOutput("post_reset_data",        128'(dcache_data_o), 128'h30);

        $display("%0d/%0d checks passed", pass_count, check_count);
        $finish;
    end

endmodule
